// File: rtl/uart_tx_arbiter_if.sv
// Memory-style bus between the arbiter (master) and the shared UART transmitter (slave).
// mem_rdata[0] reports "transmit buffer empty" on status reads.
interface uart_tx_arbiter_if;
    logic        uart_enable;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_instr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;

    modport master (
        output uart_enable,
        output mem_valid,
        output mem_instr,
        output mem_wstrb,
        output mem_wdata,
        output mem_addr,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  uart_enable,
        input  mem_valid,
        input  mem_instr,
        input  mem_wstrb,
        input  mem_wdata,
        input  mem_addr,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte streams, with
// packet locking and a poll-then-write sequence so each byte lands in an empty buffer.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 2,
    parameter logic [31:0] UART_ADDR    = 32'h0200_0000,
    parameter int unsigned LOCK_TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    uart_tx_arbiter_if.master      mem,
    output logic                   busy,
    output logic [1:0]             grant_id
);

    localparam int unsigned    CNT_W    = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (LOCK_TIMEOUT > 0) ? CNT_W'(LOCK_TIMEOUT - 1) : '0;
    localparam logic [2:0]     NREQ3    = 3'(NUM_REQ);
    localparam logic [1:0]     LAST_IDX = 2'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        POLL,
        WRITE,
        GAP
    } state_e;

    state_e             state_q, state_d;
    state_e             after_gap_q, after_gap_d;
    logic [7:0]         hold_q, hold_d;
    logic               lock_q, lock_d;
    logic [1:0]         owner_q, owner_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         grant_q, grant_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic               mem_valid_q, mem_valid_d;
    logic [3:0]         mem_wstrb_q, mem_wstrb_d;
    logic               busy_q, busy_d;

    logic               owner_valid;
    logic               lock_eff;
    logic [NUM_REQ-1:0] eligible;
    logic               win_found;
    logic [1:0]         win_idx;
    logic [2:0]         pos;

    // Only the buffer-empty flag of the status word carries meaning.
    logic unused_rdata;
    assign unused_rdata = ^mem.mem_rdata[31:1];

    always_comb begin
        state_d     = state_q;
        after_gap_d = after_gap_q;
        hold_d      = hold_q;
        lock_d      = lock_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        req_ready_d = '0;
        owner_valid = 1'b0;
        lock_eff    = lock_q;
        eligible    = '0;
        win_found   = 1'b0;
        win_idx     = '0;
        pos         = '0;

        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (owner_q == 2'(i)) owner_valid = req_valid[i];
        end

        unique case (state_q)
            IDLE: begin
                // An expiring lock reopens arbitration in this same cycle.
                if (lock_q && !owner_valid && (LOCK_TIMEOUT != 0)) begin
                    if (cnt_q == CNT_LAST) begin
                        lock_eff = 1'b0;
                        lock_d   = 1'b0;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    eligible[i] = req_valid[i] && (!lock_eff || (owner_q == 2'(i)));
                end

                for (int unsigned k = 0; k < NUM_REQ; k++) begin
                    pos = {1'b0, rr_ptr_q} + 3'(k);
                    if (pos >= NREQ3) pos = pos - NREQ3;
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        if (!win_found && (pos == 3'(i)) && eligible[i]) begin
                            win_found = 1'b1;
                            win_idx   = 2'(i);
                        end
                    end
                end

                if (win_found) begin
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        if (win_idx == 2'(i)) begin
                            req_ready_d[i] = 1'b1;
                            hold_d         = req_data[8*i +: 8];
                            lock_d         = !req_last[i];
                        end
                    end
                    owner_d  = win_idx;
                    grant_d  = win_idx;
                    rr_ptr_d = (win_idx == LAST_IDX) ? 2'd0 : win_idx + 2'd1;
                    cnt_d    = '0;
                    state_d  = POLL;
                end
            end

            POLL: begin
                if (mem.mem_ready) begin
                    after_gap_d = mem.mem_rdata[0] ? WRITE : POLL;
                    state_d     = GAP;
                end
            end

            WRITE: begin
                if (mem.mem_ready) begin
                    after_gap_d = IDLE;
                    state_d     = GAP;
                end
            end

            GAP: begin
                if (!mem.mem_ready) state_d = after_gap_q;
            end

            default: state_d = IDLE;
        endcase

        mem_valid_d = (state_d == POLL) || (state_d == WRITE);
        mem_wstrb_d = (state_d == WRITE) ? 4'b0001 : 4'b0000;
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            after_gap_q <= IDLE;
            hold_q      <= '0;
            lock_q      <= 1'b0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            grant_q     <= '0;
            req_ready_q <= '0;
            mem_valid_q <= 1'b0;
            mem_wstrb_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            after_gap_q <= after_gap_d;
            hold_q      <= hold_d;
            lock_q      <= lock_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            req_ready_q <= req_ready_d;
            mem_valid_q <= mem_valid_d;
            mem_wstrb_q <= mem_wstrb_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready       = req_ready_q;
    assign busy            = busy_q;
    assign grant_id        = grant_q;
    assign mem.mem_valid   = mem_valid_q;
    assign mem.uart_enable = mem_valid_q;
    assign mem.mem_instr   = 1'b0;
    assign mem.mem_wstrb   = mem_wstrb_q;
    assign mem.mem_wdata   = {24'b0, hold_q};
    assign mem.mem_addr    = UART_ADDR;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues drive bytes, a registered-ready
// transmitter model answers, and every completed write is matched against expected bytes.
module tb_uart_tx_arbiter;

    localparam logic [31:0] UART_ADDR = 32'h0200_0000;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } req_item_t;

    typedef struct {
        logic [7:0] data;
        logic [1:0] id;
    } exp_item_t;

    logic        clk;
    logic        resetn;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic        busy;
    logic [1:0]  grant_id;

    uart_tx_arbiter_if bus ();

    uart_tx_arbiter #(
        .NUM_REQ      (2),
        .UART_ADDR    (UART_ADDR),
        .LOCK_TIMEOUT (16)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .mem       (bus),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    int n_vec  = 0;
    int n_miss = 0;

    req_item_t rq0[$];
    req_item_t rq1[$];
    exp_item_t exp_q[$];
    int        rdy_t[$];

    int cyc        = 0;
    int n_reads    = 0;
    int n_writes   = 0;
    int polls_seen = 0;
    int full_polls = 0;
    logic prev_rdy   = 1'b0;
    logic prev_done  = 1'b0;
    logic prev_valid = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter model: registered ready, buffer reads full until full_polls reads were seen.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) bus.mem_ready <= 1'b0;
        else         bus.mem_ready <= bus.mem_valid;
    end

    always @(posedge clk) begin
        if (bus.mem_valid && bus.mem_ready && (bus.mem_wstrb == 4'b0000))
            polls_seen <= polls_seen + 1;
    end

    assign bus.mem_rdata = {31'b0, (polls_seen >= full_polls)};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Monitor and requester drivers, both on the falling edge.
    initial begin
        exp_item_t e;
        logic      done;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (|req_ready) begin
                check("rdy_onehot", 32'($onehot(req_ready)), 1);
                check("rdy_back_to_back", 32'(prev_rdy), 0);
                rdy_t.push_back(cyc);
            end
            prev_rdy = |req_ready;

            if (bus.mem_valid && !prev_valid) check("start_while_ready", 32'(bus.mem_ready), 0);
            done = bus.mem_valid && bus.mem_ready;
            if (done) begin
                check("no_idle_gap", 32'(prev_done), 0);
                check("addr", bus.mem_addr, UART_ADDR);
                check("instr", 32'(bus.mem_instr), 0);
                check("enable", 32'(bus.uart_enable), 1);
                if (bus.mem_wstrb == 4'b0000) begin
                    n_reads++;
                end else begin
                    n_writes++;
                    check("wstrb", 32'(bus.mem_wstrb), 32'h1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", bus.mem_wdata, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("wdata", bus.mem_wdata, {24'b0, e.data});
                        check("grant_id", 32'(grant_id), 32'(e.id));
                    end
                end
            end
            prev_done  = done;
            prev_valid = bus.mem_valid;

            if (req_ready[0] && rq0.size() != 0) void'(rq0.pop_front());
            if (req_ready[1] && rq1.size() != 0) void'(rq1.pop_front());
            req_valid[0] = (rq0.size() != 0);
            req_valid[1] = (rq1.size() != 0);
            if (rq0.size() != 0) begin
                req_data[7:0] = rq0[0].data;
                req_last[0]   = rq0[0].last;
            end
            if (rq1.size() != 0) begin
                req_data[15:8] = rq1[0].data;
                req_last[1]    = rq1[0].last;
            end
        end
    end

    task automatic send(input int id, input logic [7:0] d, input logic last);
        req_item_t it;
        it.data = d;
        it.last = last;
        if (id == 0) rq0.push_back(it);
        else         rq1.push_back(it);
    endtask

    task automatic expect_byte(input int id, input logic [7:0] d);
        exp_item_t e;
        e.data = d;
        e.id   = 2'(id);
        exp_q.push_back(e);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("rst_mem_valid", 32'(bus.mem_valid), 0);
        check("rst_enable", 32'(bus.uart_enable), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_wstrb", 32'(bus.mem_wstrb), 0);
        check("rst_wdata", bus.mem_wdata, 0);
        check("rst_grant", 32'(grant_id), 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        rdy_t.delete();
    endtask

    task automatic wait_done(input string tag, input int budget);
        int   n = 0;
        logic ok;
        ok = 1'b0;
        while (n < budget) begin
            @(posedge clk);
            #1;
            n++;
            if (rq0.size() == 0 && rq1.size() == 0 && exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_completes"}, 32'(ok), 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, w0;
        logic seen;
        resetn = 1'b0;

        // Single byte into an empty buffer: one status read, one write.
        apply_reset();
        r0 = n_reads; w0 = n_writes;
        send(0, 8'h41, 1'b1);
        expect_byte(0, 8'h41);
        wait_done("single", 100);
        check("single_reads", 32'(n_reads - r0), 1);
        check("single_writes", 32'(n_writes - w0), 1);

        // Buffer reports full for three polls, then empty.
        apply_reset();
        r0 = n_reads; w0 = n_writes;
        full_polls = polls_seen + 3;
        send(0, 8'h5A, 1'b1);
        expect_byte(0, 8'h5A);
        wait_done("full", 200);
        check("full_reads", 32'(n_reads - r0), 4);
        check("full_writes", 32'(n_writes - w0), 1);

        // Round-robin with both requesters always valid; accepts every 9 cycles.
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            send(0, 8'hA0 + 8'(i), 1'b1);
            send(1, 8'hB0 + 8'(i), 1'b1);
            expect_byte(0, 8'hA0 + 8'(i));
            expect_byte(1, 8'hB0 + 8'(i));
        end
        wait_done("rr", 300);
        check("rr_accepts", 32'(rdy_t.size()), 8);
        for (int i = 1; i < rdy_t.size(); i++) check("rr_accept_spacing", 32'(rdy_t[i] - rdy_t[i-1]), 9);

        // Packet lock: three-byte packet from req 0 is not interleaved with req 1.
        apply_reset();
        send(0, 8'hC0, 1'b0);
        send(0, 8'hC1, 1'b0);
        send(0, 8'hC2, 1'b1);
        send(1, 8'hD0, 1'b1);
        expect_byte(0, 8'hC0);
        expect_byte(0, 8'hC1);
        expect_byte(0, 8'hC2);
        expect_byte(1, 8'hD0);
        wait_done("lock", 300);

        // Lock timeout: owner goes quiet; req 1 wins on the 16th idle cycle (accept 9 + 15 later).
        apply_reset();
        send(0, 8'hE0, 1'b0);
        send(1, 8'hF0, 1'b1);
        expect_byte(0, 8'hE0);
        expect_byte(1, 8'hF0);
        wait_done("timeout", 300);
        check("timeout_accepts", 32'(rdy_t.size()), 2);
        if (rdy_t.size() >= 2) check("timeout_spacing", 32'(rdy_t[1] - rdy_t[0]), 24);

        // Reset while the write is pending: byte is dropped, round-robin restarts at 0.
        apply_reset();
        w0 = n_writes;
        send(0, 8'h55, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.mem_valid && bus.mem_wstrb == 4'b0001) begin
                seen = 1'b1;
                break;
            end
        end
        check("midwrite_reached", 32'(seen), 1);
        #1;
        resetn = 1'b0;
        #1;
        check("midwrite_valid", 32'(bus.mem_valid), 0);
        check("midwrite_busy", 32'(busy), 0);
        repeat (3) @(negedge clk);
        check("midwrite_no_write", 32'(n_writes - w0), 0);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        send(0, 8'h66, 1'b1);
        send(1, 8'h77, 1'b1);
        expect_byte(0, 8'h66);
        expect_byte(1, 8'h77);
        wait_done("after_reset", 200);
        check("after_reset_writes", 32'(n_writes - w0), 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter peripheral among NUM_REQ byte-stream requesters, e.g. the CPU console path and a debug/trace streamer.
- Picks requesters round-robin and supports packet locking via req_last.
- Drives the transmitter's memory-style slave port as its only master.
- Runs a poll-then-write sequence so every byte is written exactly once, and only when the transmitter's one-byte buffer is empty.

Parameters:
- NUM_REQ, 2, number of requesters (legal range 2..4).
- UART_ADDR, 32'h0200_0000, value driven on mem_addr for every transaction.
- LOCK_TIMEOUT, 1024, idle cycles of the lock owner after which a packet lock is force-released (0 = never).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  8*NUM_REQ  byte for requester i at [8i+7:8i]
- req_last  in  NUM_REQ  byte ends a packet; releases the lock
- req_ready  out  NUM_REQ  one-cycle accept pulse, at most one bit set
- uart_enable  out  1  transmitter select; equals mem_valid
- mem_valid  out  1  transaction request to transmitter
- mem_ready  in  1  transmitter acknowledge
- mem_instr  out  1  constant 0
- mem_wstrb  out  4  4'b0000 = status read, 4'b0001 = byte write
- mem_wdata  out  32  {24'b0, hold_byte}
- mem_addr  out  32  UART_ADDR
- mem_rdata  in  32  bit0 = transmitter buffer empty
- busy  out  1  high in any state other than IDLE
- grant_id  out  2  index of the last accepted requester

Behaviour:
- Reset values: state = IDLE; mem_valid, uart_enable, req_ready, busy = 0; mem_wstrb = 0; mem_wdata = 0; grant_id = 0; lock = 0; rr_ptr = 0; timeout counter = 0. All outputs are registered.
- Transmitter slave contract:
  - mem_ready is registered: it goes high the cycle after mem_valid and stays high while mem_valid is held.
  - mem_ready falls one cycle after mem_valid drops.
  - A write is dropped silently if the buffer is full.
  - The next transaction must not start until mem_ready has returned to 0.
- IDLE:
  - If unlocked: pick the first requester with req_valid set, searching from rr_ptr upward and wrapping.
  - If locked: consider only the lock owner.
  - On a winner: pulse req_ready[w] for 1 cycle and capture req_data and req_last into the hold register. Set grant_id = w and rr_ptr = w+1 mod NUM_REQ. Set lock = ~req_last and owner = w. Go to POLL.
- POLL: mem_valid = 1, mem_wstrb = 0. On mem_ready = 1, sample mem_rdata[0]:
  - 1 → next = WRITE.
  - 0 → next = POLL.
  - Either way, pass through GAP first.
- WRITE: mem_valid = 1, mem_wstrb = 4'b0001. On mem_ready → GAP, then IDLE.
- GAP: mem_valid = 0. Hold while mem_ready = 1; on mem_ready = 0, advance to the stored next state.
- Throughput: with an empty buffer, the next byte is accepted 9 cycles after the previous accept.
  - Accept at cycle 0; POLL in cycles 1–2; GAP in 3–4; WRITE in 5–6; GAP in 7–8; IDLE at 9.
- Lock timeout:
  - While locked, in IDLE, with the owner's req_valid = 0, the counter increments each cycle. It resets on any accept.
  - At LOCK_TIMEOUT the lock clears and arbitration reopens in the same IDLE cycle.
- Non-owner requesters stay unserved while the lock is held. req_valid from other requesters is ignored outside IDLE.
- Reset mid-transaction returns to IDLE and discards the held byte. The requester has already seen req_ready, so that byte is lost by design.
- req_ready is never asserted outside IDLE and never asserted in two consecutive cycles.

Test Plan:
- Single byte: req 0 sends 8'h41 with last = 1; mem_rdata[0] = 1.
  - Expect one read (wstrb 0) then one write with wstrb 4'b0001 and wdata 32'h41.
  - Next req_ready is possible at cycle 9 after the accept.
- Buffer full: hold mem_rdata[0] = 0 for 3 polls, then 1.
  - Expect exactly 4 reads, then 1 write.
  - mem_valid is low for at least 1 cycle between each pair of transactions.
- Round-robin: both requesters continuously valid, last = 1, data 8'hA0.. and 8'hB0...
  - Writes alternate A0, B0, A1, B1; grant_id toggles 0, 1, 0, 1.
- Packet lock: req 0 sends 3 bytes with last = 0, 0, 1 while req 1 stays valid.
  - All 3 req 0 bytes are written before any req 1 byte.
- Lock timeout: LOCK_TIMEOUT = 16. Req 0 sends 1 byte with last = 0, then goes idle; req 1 is valid.
  - The req 1 byte is accepted 16 IDLE cycles later.
- Reset mid-WRITE: assert resetn = 0 in cycle 5.
  - mem_valid = 0 and busy = 0 immediately; no write completes.
  - After release, normal operation resumes with rr_ptr = 0.
